// File: rtl/e203_subsys_rst_pkg.sv
// Shared types and constants for the subsystem reset sequencer.
//   rst_state_e   : sequencer FSM states
//   RST_CAUSE_*   : encodings of the last reset cause
//   cnt_width()   : width of the hold/gap cycle counter
package e203_subsys_rst_pkg;

  typedef enum logic [2:0] {
    S_POR_HOLD = 3'd0,
    S_RELEASE  = 3'd1,
    S_RUN      = 3'd2,
    S_ASSERT   = 3'd3,
    S_HOLD     = 3'd4
  } rst_state_e;

  localparam logic [1:0] RST_CAUSE_POR = 2'b00;
  localparam logic [1:0] RST_CAUSE_SW  = 2'b01;
  localparam logic [1:0] RST_CAUSE_WDG = 2'b10;

  // Counter must reach max(hold, gap) - 1; one spare bit keeps headroom.
  function automatic int unsigned cnt_width(input int unsigned hold_cyc,
                                            input int unsigned gap_cyc);
    int unsigned mx;
    mx = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
    return $clog2(mx) + 1;
  endfunction

endpackage

// File: rtl/e203_subsys_rst_seq_sync.sv
// Internal reset generator for the sequencer: asynchronous assert,
// two-flop synchronised deassert. In test_mode the raw rst_n_a is passed
// through so the whole block is directly controllable from the pin.
// Ports:
//   clk, rst_n_a  : clock and async active-low reset
//   test_mode     : 1 selects rst_n_a as the internal reset
//   rst_n_sync_c  : internal active-low reset (combinational mux output)
module e203_subsys_rst_seq_sync (
  input  logic clk,
  input  logic rst_n_a,
  input  logic test_mode,
  output logic rst_n_sync_c
);

  logic [1:0] sync_q;

  // Two-stage synchroniser, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_n_sync_c = test_mode ? rst_n_a : sync_q[1];

endmodule

// File: rtl/e203_subsys_rst_seq_ctrl.sv
// Subsystem reset sequencer. After a power-on hold, releases NUM_DOM reset
// domains in order (domain 0 first) spaced GAP_CYC cycles apart. A software
// or watchdog request while running asserts domains in reverse order, holds
// all of them for HOLD_CYC cycles, then re-releases in order.
// Optional feature macro: E203_SUBSYS_RST_CAUSE_EN adds the rst_cause port
// with a sticky record of the last reset cause.
// Ports:
//   clk, rst_n_a  : clock and async active-low reset
//   test_mode     : 1 drives every dom_rst_n straight from rst_n_a
//   sw_rst_req    : software reset request (level, honoured in S_RUN only)
//   wdg_rst_req   : watchdog reset request (level, honoured in S_RUN only)
//   dom_rst_n     : per-domain active-low resets
//   rst_busy      : 1 whenever the sequencer is not in S_RUN
//   rst_done      : one-cycle pulse on release of the last domain
//   rst_cause     : last reset cause (POR/SW/WDG), macro-enabled only
module e203_subsys_rst_seq_ctrl
  import e203_subsys_rst_pkg::*;
#(
  parameter int unsigned NUM_DOM  = 4,
  parameter int unsigned GAP_CYC  = 8,
  parameter int unsigned HOLD_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n_a,
  input  logic               test_mode,
  input  logic               sw_rst_req,
  input  logic               wdg_rst_req,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               rst_busy,
  output logic               rst_done
`ifdef E203_SUBSYS_RST_CAUSE_EN
  ,
  output logic [1:0]         rst_cause
`endif
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYC, GAP_CYC);
  localparam int unsigned IDX_W = $clog2(NUM_DOM);

  logic                rst_n_int;
  rst_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_DOM-1:0]  dom_q, dom_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [1:0]          cause_q, cause_d;

  e203_subsys_rst_seq_sync u_sync (
    .clk          (clk),
    .rst_n_a      (rst_n_a),
    .test_mode    (test_mode),
    .rst_n_sync_c (rst_n_int)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= S_POR_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      cause_q <= RST_CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = 1'b0;
    cause_d = cause_q;

    unique case (state_q)
      S_POR_HOLD, S_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          dom_d[idx_q] = 1'b1;
          cnt_d        = '0;
          // The last index is not advanced so idx never wraps.
          if (idx_q == IDX_W'(NUM_DOM - 1)) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RUN: begin
        if (sw_rst_req || wdg_rst_req) begin
          state_d = S_ASSERT;
          idx_d   = IDX_W'(NUM_DOM - 1);
          cause_d = wdg_rst_req ? RST_CAUSE_WDG : RST_CAUSE_SW;
        end
      end

      S_ASSERT: begin
        // Reverse order: highest domain goes back into reset first.
        dom_d[idx_q] = 1'b0;
        if (idx_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      default: begin
        state_d = S_POR_HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        dom_d   = '0;
      end
    endcase

    busy_d = (state_d != S_RUN);
  end

  // DFT bypass: domain resets follow the pin with no clock dependency.
  assign dom_rst_n = test_mode ? {NUM_DOM{rst_n_a}} : dom_q;
  assign rst_busy  = busy_q;
  assign rst_done  = done_q;

`ifdef E203_SUBSYS_RST_CAUSE_EN
  assign rst_cause = cause_q;
`else
  logic unused_cause;
  assign unused_cause = ^cause_q;
`endif

endmodule
